// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared FSM state type and lane-length helpers for shift_par
package shift_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Width wide enough to hold a lane count of 0..n.
    function automatic int len_w(input int n);
        return $clog2(n + 1);
    endfunction

    // A requested length of 0 or anything above n means "all n lanes".
    function automatic int clamp_len(input int wl, input int n);
        return (wl == 0 || wl > n) ? n : wl;
    endfunction

endpackage

// File: rtl/shift_par_if.sv
// rtl/shift_par_if.sv - producer/consumer bundle of shift_par
interface shift_par_if
    import shift_pkg::*;
#(
    parameter int OUT_W     = 8,
    parameter int NUM_LANES = 2
);
    localparam int IN_W  = OUT_W * NUM_LANES;
    localparam int LEN_W = len_w(NUM_LANES);

    logic [IN_W-1:0]  in;
    logic [LEN_W-1:0] wr_len;
    logic             wr;
    logic             full;
    logic [OUT_W-1:0] out;
    logic             out_valid;
    logic             out_rd;
    logic             out_last;
    logic             empty;
    logic             ovf;

    modport master (
        output in, wr_len, wr, out_rd,
        input  full, out, out_valid, out_last, empty, ovf
    );

    modport slave (
        input  in, wr_len, wr, out_rd,
        output full, out, out_valid, out_last, empty, ovf
    );

endinterface

// File: rtl/shift_lane_mux.sv
// rtl/shift_lane_mux.sv - word shift register with output-lane select
module shift_lane_mux #(
    parameter int OUT_W     = 8,
    parameter int NUM_LANES = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load_i,
    input  logic [OUT_W*NUM_LANES-1:0]   data_i,
    input  logic                         shift_i,
    output logic [OUT_W-1:0]             lane_o
);
    localparam int IN_W = OUT_W * NUM_LANES;

    logic [IN_W-1:0] sr_q, sr_d;

    // Lanes always move toward the output end, so the lane presented is fixed.
    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = data_i;
        end else if (shift_i) begin
            sr_d = MSB_FIRST ? (sr_q << OUT_W) : (sr_q >> OUT_W);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    generate
        if (MSB_FIRST) begin : g_msb
            assign lane_o = sr_q[IN_W-1 -: OUT_W];
        end else begin : g_lsb
            assign lane_o = sr_q[OUT_W-1:0];
        end
    endgenerate

endmodule

// File: rtl/shift_par.sv
// rtl/shift_par.sv - parallel word to lane serializer; SHIFT_PAR_HOLD_EN adds a one-word holding slot
module shift_par
    import shift_pkg::*;
#(
    parameter int OUT_W     = 8,
    parameter int NUM_LANES = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    shift_par_if.slave  bus
);
    localparam int IN_W  = OUT_W * NUM_LANES;
    localparam int LEN_W = len_w(NUM_LANES);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, len_q;
    logic             ovf_q;
    logic             hold_vld_q;
    logic [IN_W-1:0]  hold_data_q;
    logic [LEN_W-1:0] hold_len_q;

    logic             lane_acc, last_acc, wr_ok;
    logic             load, load_from_hold, shift;
    logic [LEN_W-1:0] wr_len_c;
    logic [IN_W-1:0]  load_data;

    assign wr_len_c  = LEN_W'(clamp_len(int'(bus.wr_len), NUM_LANES));
    assign lane_acc  = (state_q == SHIFT) && bus.out_rd;
    assign last_acc  = lane_acc && (cnt_q == len_q - 1'b1);
    assign wr_ok     = bus.wr && !bus.full;
    assign load_data = load_from_hold ? hold_data_q : bus.in;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // On the last lane a held word wins over a fresh write; either reloads with no bubble.
    always_comb begin
        state_d        = state_q;
        load           = 1'b0;
        load_from_hold = 1'b0;
        shift          = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_ok) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last_acc) begin
                    if (hold_vld_q) begin
                        load           = 1'b1;
                        load_from_hold = 1'b1;
                    end else if (wr_ok) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (lane_acc) begin
                    shift = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.out_valid = (state_q == SHIFT);
        bus.out_last  = (state_q == SHIFT) && (cnt_q == len_q - 1'b1);
        bus.empty     = (state_q == IDLE) && !hold_vld_q;
`ifdef SHIFT_PAR_HOLD_EN
        bus.full      = (state_q == SHIFT) && hold_vld_q && !last_acc;
`else
        bus.full      = (state_q == SHIFT) && !last_acc;
`endif
        bus.ovf       = ovf_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
            len_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (load) begin
                cnt_q <= '0;
                len_q <= load_from_hold ? hold_len_q : wr_len_c;
            end else if (shift) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (bus.wr && bus.full) begin
                ovf_q <= 1'b1;
            end
        end
    end

`ifdef SHIFT_PAR_HOLD_EN
    logic hold_wr;

    // A write on the final lane with an empty hold slot goes straight to the shifter.
    assign hold_wr = wr_ok && (state_q == SHIFT) && !(last_acc && !hold_vld_q);

    always_ff @(posedge clk) begin
        if (!reset) begin
            hold_vld_q  <= 1'b0;
            hold_data_q <= '0;
            hold_len_q  <= '0;
        end else if (hold_wr) begin
            hold_vld_q  <= 1'b1;
            hold_data_q <= bus.in;
            hold_len_q  <= wr_len_c;
        end else if (load_from_hold) begin
            hold_vld_q  <= 1'b0;
        end
    end
`else
    assign hold_vld_q  = 1'b0;
    assign hold_data_q = '0;
    assign hold_len_q  = '0;
`endif

    shift_lane_mux #(
        .OUT_W    (OUT_W),
        .NUM_LANES(NUM_LANES),
        .MSB_FIRST(MSB_FIRST)
    ) u_lane_mux (
        .clk    (clk),
        .reset  (reset),
        .load_i (load),
        .data_i (load_data),
        .shift_i(shift),
        .lane_o (bus.out)
    );

endmodule

// File: tb/tb_shift_par.sv
// tb/tb_shift_par.sv - directed bench for shift_par; hold-slot steps depend on SHIFT_PAR_HOLD_EN
module tb_shift_par;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    shift_par_if #(.OUT_W(8), .NUM_LANES(2)) if0 ();
    shift_par_if #(.OUT_W(8), .NUM_LANES(4)) if1 ();

    shift_par #(.OUT_W(8), .NUM_LANES(2), .MSB_FIRST(1'b1)) u0 (
        .clk  (clk),
        .reset(reset),
        .bus  (if0.slave)
    );

    shift_par #(.OUT_W(8), .NUM_LANES(4), .MSB_FIRST(1'b0)) u1 (
        .clk  (clk),
        .reset(reset),
        .bus  (if1.slave)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_lane0(input string tag, input logic [7:0] d, input logic last);
        chk({tag, ".valid"}, 32'(if0.out_valid), 32'd1);
        chk({tag, ".out"},   32'(if0.out), 32'(d));
        chk({tag, ".last"},  32'(if0.out_last), 32'(last));
    endtask

    task automatic chk_lane1(input string tag, input logic [7:0] d, input logic last);
        chk({tag, ".valid"}, 32'(if1.out_valid), 32'd1);
        chk({tag, ".out"},   32'(if1.out), 32'(d));
        chk({tag, ".last"},  32'(if1.out_last), 32'(last));
    endtask

    initial begin
        reset = 1'b0;
        if0.in = '0; if0.wr_len = '0; if0.wr = 1'b0; if0.out_rd = 1'b0;
        if1.in = '0; if1.wr_len = '0; if1.wr = 1'b0; if1.out_rd = 1'b0;
        tick();
        tick();
        chk("rst.valid", 32'(if0.out_valid), 32'd0);
        chk("rst.last",  32'(if0.out_last), 32'd0);
        chk("rst.full",  32'(if0.full), 32'd0);
        chk("rst.empty", 32'(if0.empty), 32'd1);
        chk("rst.ovf",   32'(if0.ovf), 32'd0);
        chk("rst.empty1", 32'(if1.empty), 32'd1);
        reset = 1'b1;
        tick();

        // Default order, full word, streaming consumer
        if0.in = 16'hA55A; if0.wr_len = 2'd0; if0.wr = 1'b1; if0.out_rd = 1'b1;
        tick();
        if0.wr = 1'b0;
        chk_lane0("msb.l0", 8'hA5, 1'b0);
        tick();
        chk_lane0("msb.l1", 8'h5A, 1'b1);
        tick();
        chk("msb.end.valid", 32'(if0.out_valid), 32'd0);
        chk("msb.end.empty", 32'(if0.empty), 32'd1);

        // LSB-first, 4 lanes, 3 valid
        if1.in = 32'h11223344; if1.wr_len = 3'd3; if1.wr = 1'b1; if1.out_rd = 1'b1;
        tick();
        if1.wr = 1'b0;
        chk_lane1("lsb.l0", 8'h44, 1'b0);
        tick();
        chk_lane1("lsb.l1", 8'h33, 1'b0);
        tick();
        chk_lane1("lsb.l2", 8'h22, 1'b1);
        tick();
        chk("lsb.end.valid", 32'(if1.out_valid), 32'd0);
        chk("lsb.end.empty", 32'(if1.empty), 32'd1);

        // wr_len above NUM_LANES clamps to all four lanes
        if1.wr_len = 3'd7; if1.wr = 1'b1;
        tick();
        if1.wr = 1'b0;
        chk_lane1("clamp.l0", 8'h44, 1'b0);
        tick();
        chk_lane1("clamp.l1", 8'h33, 1'b0);
        tick();
        chk_lane1("clamp.l2", 8'h22, 1'b0);
        tick();
        chk_lane1("clamp.l3", 8'h11, 1'b1);
        tick();
        chk("clamp.end.valid", 32'(if1.out_valid), 32'd0);

        // Consumer stall keeps the first lane steady
        if0.in = 16'hA55A; if0.wr_len = 2'd0; if0.wr = 1'b1; if0.out_rd = 1'b0;
        tick();
        if0.wr = 1'b0;
        chk_lane0("stall.first", 8'hA5, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_lane0("stall.hold", 8'hA5, 1'b0);
        end
        if0.out_rd = 1'b1;
        tick();
        chk_lane0("stall.l1", 8'h5A, 1'b1);
        tick();
        chk("stall.end.empty", 32'(if0.empty), 32'd1);

        // Write on the final-lane acceptance passes straight through
        if0.in = 16'hA55A; if0.wr = 1'b1; if0.out_rd = 1'b1;
        tick();
        if0.wr = 1'b0;
        tick();
        chk_lane0("pt.l1", 8'h5A, 1'b1);
        if0.in = 16'h1234; if0.wr = 1'b1;
        #1;
        chk("pt.full", 32'(if0.full), 32'd0);
        tick();
        if0.wr = 1'b0;
        chk_lane0("pt.n0", 8'h12, 1'b0);
        tick();
        chk_lane0("pt.n1", 8'h34, 1'b1);
        tick();
        chk("pt.end.empty", 32'(if0.empty), 32'd1);
        chk("pt.ovf", 32'(if0.ovf), 32'd0);

`ifdef SHIFT_PAR_HOLD_EN
        // Back-to-back writes land in shifter then hold, drained without a gap
        if0.in = 16'h1234; if0.wr = 1'b1; if0.out_rd = 1'b1;
        tick();
        if0.in = 16'h5678;
        #1;
        chk("hold.full0", 32'(if0.full), 32'd0);
        tick();
        if0.wr = 1'b0;
        chk_lane0("hold.l0", 8'h12, 1'b0);
        tick();
        chk_lane0("hold.l1", 8'h34, 1'b1);
        tick();
        chk_lane0("hold.l2", 8'h56, 1'b0);
        tick();
        chk_lane0("hold.l3", 8'h78, 1'b1);
        tick();
        chk("hold.end.empty", 32'(if0.empty), 32'd1);

        // Both slots occupied -> full, extra write dropped
        if0.out_rd = 1'b0; if0.in = 16'h1234; if0.wr = 1'b1;
        tick();
        if0.in = 16'h5678;
        tick();
        if0.in = 16'hABCD;
        #1;
        chk("hold.full1", 32'(if0.full), 32'd1);
        tick();
        if0.wr = 1'b0;
        chk("hold.ovf", 32'(if0.ovf), 32'd1);
        if0.out_rd = 1'b1;
        chk_lane0("hold.d0", 8'h12, 1'b0);
        tick();
        chk_lane0("hold.d1", 8'h34, 1'b1);
        tick();
        chk_lane0("hold.d2", 8'h56, 1'b0);
        tick();
        chk_lane0("hold.d3", 8'h78, 1'b1);
        tick();
        chk("hold.d.empty", 32'(if0.empty), 32'd1);
`else
        // No hold slot: a second write during SHIFT is dropped
        if0.in = 16'hA55A; if0.wr = 1'b1; if0.out_rd = 1'b0;
        tick();
        if0.in = 16'h1234;
        #1;
        chk("drop.full", 32'(if0.full), 32'd1);
        tick();
        if0.wr = 1'b0;
        chk("drop.ovf", 32'(if0.ovf), 32'd1);
        chk_lane0("drop.l0", 8'hA5, 1'b0);
        if0.out_rd = 1'b1;
        tick();
        chk_lane0("drop.l1", 8'h5A, 1'b1);
        tick();
        chk("drop.end.valid", 32'(if0.out_valid), 32'd0);
        chk("drop.end.empty", 32'(if0.empty), 32'd1);
        chk("drop.ovf.sticky", 32'(if0.ovf), 32'd1);
`endif

        // Reset mid-word discards everything, including ovf
        if0.in = 16'hA55A; if0.wr = 1'b1; if0.out_rd = 1'b0;
        tick();
        if0.wr = 1'b1; if0.in = 16'h9999;
        tick();
        if0.wr = 1'b0;
        chk("mid.valid", 32'(if0.out_valid), 32'd1);
        chk("mid.ovf", 32'(if0.ovf), 32'd1);
        reset = 1'b0;
        if0.wr = 1'b1; if0.out_rd = 1'b1;
        tick();
        chk("mid.rst.valid", 32'(if0.out_valid), 32'd0);
        chk("mid.rst.empty", 32'(if0.empty), 32'd1);
        chk("mid.rst.ovf",   32'(if0.ovf), 32'd0);
        chk("mid.rst.full",  32'(if0.full), 32'd0);
        if0.wr = 1'b0; if0.out_rd = 1'b0;
        reset = 1'b1;
        tick();
        chk("post.empty", 32'(if0.empty), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_par.md
SHIFT_PAR -- requirements
Module: shift_par

Interface
REQ-001 SHALL have parameter OUT_W, default 8: width of one output lane in bits.
REQ-002 SHALL have parameter NUM_LANES, default 2, range 2..16: lanes per input word; IN_W = OUT_W*NUM_LANES.
REQ-003 SHALL have parameter MSB_FIRST, default 1: 1 = lane NUM_LANES-1 (top) first, 0 = lane 0 first.
REQ-004 SHALL have ports, clock and reset first:
  clk  in  1  single clock, all logic on rising edge
  reset  in  1  synchronous, active-low reset
  in  in  IN_W  parallel input word
  wr_len  in  LEN_W = clog2(NUM_LANES+1)  valid lanes in word; 0 means NUM_LANES
  wr  in  1  write strobe, accepted when full=0
  full  out  1  no free word slot; wr ignored
  out  out  OUT_W  current lane
  out_valid  out  1  out holds a valid lane
  out_rd  in  1  consumer takes lane when out_valid=1
  out_last  out  1  current lane is final lane of its word
  empty  out  1  no word loaded or held
  ovf  out  1  sticky: wr seen while full=1

Function
REQ-005 SHALL implement FSM IDLE (no active word) and SHIFT (active word, lane counter cnt).
REQ-006 SHALL, in IDLE on wr=1, load in, set cnt=0, capture len (wr_len, with 0 mapped to NUM_LANES), and enter SHIFT; first lane on out with out_valid=1 the next cycle (latency 1).
REQ-007 SHALL drive out from the top lane of the shift register when MSB_FIRST=1 and from lane 0 when MSB_FIRST=0, shifting by OUT_W toward the output on each accepted lane (out_valid & out_rd).
REQ-008 SHALL hold out, out_valid and out_last stable while out_valid=1 and out_rd=0.
REQ-009 SHALL assert out_last iff out_valid=1 and cnt=len-1; a wr_len above NUM_LANES SHALL be clamped to NUM_LANES.
REQ-010 SHALL, on acceptance of the last lane, load the next word if one is held or wr=1 that cycle and stay in SHIFT with no bubble; otherwise return to IDLE with out_valid=0.
REQ-011 SHALL drive full=1 when every word slot is occupied, except in the cycle the last lane is accepted, when full=0 (pass-through acceptance).
REQ-012 SHALL drop wr when full=1, leave state and data unchanged, and set ovf=1 until reset.
REQ-013 SHALL drive empty=1 iff state is IDLE and no word is held.
REQ-014 SHALL not change out while out_valid=0; its value is don't-care.

Reset
REQ-015 SHALL, with reset=0 at a clk edge, set state=IDLE, cnt=0, shift and hold registers=0, out_valid=0, out_last=0, full=0, empty=1, ovf=0, discarding any word in progress.
REQ-016 SHALL ignore wr and out_rd in any cycle where reset=0.

Configuration
REQ-017 SHALL honour macro SHIFT_PAR_HOLD_EN: when defined, add one holding word register (data+len), so one wr is accepted during SHIFT and full=1 only when the shift and hold slots are both occupied; when undefined, full=1 throughout SHIFT except under REQ-011.

Structure
REQ-018 SHALL place the state enum (IDLE, SHIFT) and the clog2-derived width helper in shared package shift_pkg.
REQ-019 SHALL keep lane select/shift datapath in sub-module shift_lane_mux (parameters OUT_W, NUM_LANES, MSB_FIRST); control and hold register stay in shift_par.

Verification
REQ-020 SHALL check: defaults, in=16'hA55A, wr_len=0, out_rd=1 -> out A5 (last=0) then 5A (last=1), then empty=1.
REQ-021 SHALL check: MSB_FIRST=0, NUM_LANES=4, in=32'h11223344, wr_len=3 -> out 44,33,22; out_last on 22; 11 never output.
REQ-022 SHALL check: out_rd held 0 for 5 cycles after first lane -> out stays A5, out_valid=1, no lane lost or repeated.
REQ-023 SHALL check: SHIFT_PAR_HOLD_EN defined, wr 16'h1234 then 16'h5678 next cycle, out_rd=1 -> 12,34,56,78 contiguous, out_valid never 0 between words.
REQ-024 SHALL check: macro undefined, second wr during SHIFT -> full=1, word dropped, ovf=1 and sticky; reset=0 mid-word -> out_valid=0, empty=1, ovf=0 next cycle.
